// File: rtl/nn_frame_loader.sv
// rtl/nn_frame_loader.sv - pixel stream to packed fixed-point frame loader for NeuralNetwork
module nn_frame_loader #(
  parameter int numInputs     = 784,
  parameter int dataWidth     = 16,
  parameter int dataFracWidth = 8,
  parameter int pixelWidth    = 8   // must not exceed dataFracWidth
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [pixelWidth-1:0]          pixIn,
  input  logic                           pixValid,
  input  logic                           pixSof,
  output logic                           pixReady,
  input  logic                           abort,
  output logic [numInputs*dataWidth-1:0] NNin,
  output logic                           NNvalid,
  input  logic                           NNoutValid,
  output logic [$clog2(numInputs+1)-1:0] pixCount,
  output logic [7:0]                     frameCount,
  output logic                           sofError
);

  localparam int CW    = $clog2(numInputs + 1);
  localparam int SHIFT = dataFracWidth - pixelWidth;

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [CW-1:0] LAST_IDX = CW'(numInputs - 1);

  logic [0:0]                     r_state;
  logic [CW-1:0]                  r_count;
  logic [numInputs*dataWidth-1:0] r_nnin;
  logic                           r_nnvalid;
  logic [7:0]                     r_frames;
  logic                           r_sof_err;

  logic                           w_accept;
  logic [CW-1:0]                  w_idx;
  logic [dataWidth-1:0]           w_pix_q;

  // Ready only while collecting a frame; RUN back-pressures upstream.
  assign pixReady = (r_state == ST_LOAD);
  assign w_accept = pixValid && pixReady;

  // SOF restarts the frame at element 0 whatever the current fill level.
  assign w_idx = pixSof ? '0 : r_count;

  // Integer pixel placed just below the binary point: p -> p / 2^pixelWidth.
  assign w_pix_q = dataWidth'(pixIn) << SHIFT;

  assign NNin       = r_nnin;
  assign NNvalid    = r_nnvalid;
  assign pixCount   = r_count;
  assign frameCount = r_frames;
  assign sofError   = r_sof_err;

  // Frame fill, hand-off to NeuralNetwork, and release on its completion; abort wins over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_LOAD;
      r_count   <= '0;
      r_nnin    <= '0;
      r_nnvalid <= 1'b0;
      r_frames  <= '0;
      r_sof_err <= 1'b0;
    end else if (abort) begin
      // NNin is intentionally left alone: stale elements are harmless until refilled.
      r_state   <= ST_LOAD;
      r_count   <= '0;
      r_nnvalid <= 1'b0;
    end else if (r_state == ST_LOAD) begin
      if (w_accept) begin
        r_nnin[int'(w_idx)*dataWidth +: dataWidth] <= w_pix_q;
        r_count <= w_idx + 1'b1;
        if (pixSof && (r_count != '0)) begin
          r_sof_err <= 1'b1;
        end
        if (w_idx == LAST_IDX) begin
          r_state   <= ST_RUN;
          r_nnvalid <= 1'b1;
        end
      end
    end else begin
      if (NNoutValid) begin
        r_state   <= ST_LOAD;
        r_count   <= '0;
        r_nnvalid <= 1'b0;
        r_frames  <= r_frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_nn_frame_loader.sv
// tb/tb_nn_frame_loader.sv - randomized self-checking bench for nn_frame_loader
module tb_nn_frame_loader;

  localparam int N  = 784;
  localparam int DW = 16;
  localparam int FW = 8;
  localparam int PW = 8;
  localparam int CW = 10;
  localparam int NS = 4;
  localparam int CS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [PW-1:0]   pixIn;
  logic            pixValid, pixSof, abort, NNoutValid;
  logic            pixReady, NNvalid, sofError;
  logic [N*DW-1:0] NNin;
  logic [CW-1:0]   pixCount;
  logic [7:0]      frameCount;

  logic             s_pixValid, s_NNoutValid, s_pixReady, s_NNvalid, s_sofError;
  logic [PW-1:0]    s_pixIn;
  logic [NS*DW-1:0] s_NNin;
  logic [CS-1:0]    s_pixCount;
  logic [7:0]       s_frameCount;

  nn_frame_loader #(.numInputs(N), .dataWidth(DW), .dataFracWidth(FW), .pixelWidth(PW)) u_dut (
    .clk(clk), .reset_n(reset_n), .pixIn(pixIn), .pixValid(pixValid), .pixSof(pixSof),
    .pixReady(pixReady), .abort(abort), .NNin(NNin), .NNvalid(NNvalid),
    .NNoutValid(NNoutValid), .pixCount(pixCount), .frameCount(frameCount), .sofError(sofError)
  );

  nn_frame_loader #(.numInputs(NS), .dataWidth(DW), .dataFracWidth(FW), .pixelWidth(PW)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .pixIn(s_pixIn), .pixValid(s_pixValid), .pixSof(1'b0),
    .pixReady(s_pixReady), .abort(1'b0), .NNin(s_NNin), .NNvalid(s_NNvalid),
    .NNoutValid(s_NNoutValid), .pixCount(s_pixCount), .frameCount(s_frameCount), .sofError(s_sofError)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame as an array of element values plus counters.
  int m_nnin[N];
  int m_count;
  bit m_run;
  int m_frames;
  bit m_sof;
  int n_acc;
  int acc_q[$];

  task automatic model_reset();
    foreach (m_nnin[i]) m_nnin[i] = 0;
    m_count = 0; m_run = 0; m_frames = 0; m_sof = 0; n_acc = 0;
    acc_q.delete();
  endtask

  // Advance one clock with the inputs already driven and update the model from them.
  task automatic tick();
    int idx;
    @(posedge clk);
    if (abort) begin
      m_run = 0; m_count = 0;
    end else if (!m_run) begin
      if (pixValid) begin
        idx = pixSof ? 0 : m_count;
        if (pixSof && m_count != 0) m_sof = 1;
        m_nnin[idx] = int'(pixIn) * (1 << (FW - PW));
        m_count = idx + 1;
        n_acc++;
        acc_q.push_back(int'(pixIn));
        if (m_count == N) m_run = 1;
      end
    end else if (NNoutValid) begin
      m_run = 0; m_count = 0; m_frames = (m_frames + 1) % 256;
    end
    #1;
  endtask

  function automatic int nnin_mismatches();
    int n = 0;
    for (int i = 0; i < N; i++) if (int'(NNin[i*DW +: DW]) != m_nnin[i]) n++;
    return n;
  endfunction

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      pixValid = 1'b1; pixSof = 1'b0; pixIn = PW'($urandom);
      tick();
    end
    pixValid = 1'b0;
  endtask

  task automatic release_frame();
    NNoutValid = 1'b1;
    tick();
    NNoutValid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (pixReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", pixReady); end
    checks++; if (NNvalid !== 1'b0) begin errors++; $display("FAIL reset_nnvalid got %0b want 0", NNvalid); end
    checks++; if (pixCount !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", pixCount); end
    checks++; if (frameCount !== 8'd0) begin errors++; $display("FAIL reset_frames got %0d want 0", frameCount); end
    checks++; if (sofError !== 1'b0) begin errors++; $display("FAIL reset_soferr got %0b want 0", sofError); end
    checks++; if (NNin !== '0) begin errors++; $display("FAIL reset_nnin nonzero want all 0"); end
  endtask

  task automatic test_full_frame();
    int bad_ready = 0;
    int early_valid = 0;
    for (int i = 0; i < N; i++) begin
      pixValid = 1'b1; pixSof = 1'b0; pixIn = PW'(i % 256);
      if (pixReady !== 1'b1) bad_ready++;
      if (NNvalid !== 1'b0) early_valid++;
      tick();
    end
    pixValid = 1'b0;
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL full_ready_low got %0d low cycles want 0", bad_ready); end
    checks++; if (early_valid != 0) begin errors++; $display("FAIL full_early_valid got %0d cycles want 0", early_valid); end
    checks++; if (NNvalid !== 1'b1) begin errors++; $display("FAIL full_nnvalid got %0b want 1", NNvalid); end
    checks++; if (pixReady !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", pixReady); end
    checks++; if (NNin[0 +: 16] !== 16'h0000) begin errors++; $display("FAIL full_el0 got %h want 0000", NNin[0 +: 16]); end
    checks++; if (NNin[255*16 +: 16] !== 16'h00FF) begin errors++; $display("FAIL full_el255 got %h want 00ff", NNin[255*16 +: 16]); end
    checks++; if (NNin[783*16 +: 16] !== 16'h000F) begin errors++; $display("FAIL full_el783 got %h want 000f", NNin[783*16 +: 16]); end
    checks++; if (pixCount !== 10'd784) begin errors++; $display("FAIL full_count got %0d want 784", pixCount); end
    checks++; if (nnin_mismatches() != 0) begin errors++; $display("FAIL full_nnin got %0d bad elements want 0", nnin_mismatches()); end
  endtask

  task automatic test_run_hold();
    logic [N*DW-1:0] snap;
    int bad_ready = 0;
    int bad_nnin = 0;
    int bad_valid = 0;
    snap = NNin;
    for (int i = 0; i < 50; i++) begin
      pixValid = 1'b1; pixIn = PW'($urandom); pixSof = ($urandom % 4) == 0;
      tick();
      if (pixReady !== 1'b0) bad_ready++;
      if (NNin !== snap) bad_nnin++;
      if (NNvalid !== 1'b1) bad_valid++;
    end
    pixValid = 1'b0; pixSof = 1'b0;
    checks++; if (bad_ready != 0) begin errors++; $display("FAIL hold_ready got %0d high cycles want 0", bad_ready); end
    checks++; if (bad_nnin != 0) begin errors++; $display("FAIL hold_nnin got %0d changed cycles want 0", bad_nnin); end
    checks++; if (bad_valid != 0) begin errors++; $display("FAIL hold_valid got %0d low cycles want 0", bad_valid); end
    checks++; if (sofError !== 1'b0) begin errors++; $display("FAIL hold_soferr got %0b want 0", sofError); end
    release_frame();
    checks++; if (NNvalid !== 1'b0) begin errors++; $display("FAIL rel_nnvalid got %0b want 0", NNvalid); end
    checks++; if (pixCount !== '0) begin errors++; $display("FAIL rel_count got %0d want 0", pixCount); end
    checks++; if (frameCount !== 8'(m_frames)) begin errors++; $display("FAIL rel_frames got %0d want %0d", frameCount, m_frames); end
    checks++; if (frameCount !== 8'd1) begin errors++; $display("FAIL rel_frames1 got %0d want 1", frameCount); end
    checks++; if (pixReady !== 1'b1) begin errors++; $display("FAIL rel_ready got %0b want 1", pixReady); end
  endtask

  task automatic test_sof();
    load_random(300);
    pixValid = 1'b1; pixSof = 1'b1; pixIn = 8'hAB;
    tick();
    pixValid = 1'b0; pixSof = 1'b0;
    checks++; if (sofError !== 1'b1) begin errors++; $display("FAIL sof_err got %0b want 1", sofError); end
    checks++; if (pixCount !== 10'd1) begin errors++; $display("FAIL sof_count got %0d want 1", pixCount); end
    checks++; if (NNin[0 +: 16] !== 16'h00AB) begin errors++; $display("FAIL sof_el0 got %h want 00ab", NNin[0 +: 16]); end
    load_random(N - 1);
    checks++; if (NNvalid !== 1'b1) begin errors++; $display("FAIL sof_nnvalid got %0b want 1", NNvalid); end
    checks++; if (nnin_mismatches() != 0) begin errors++; $display("FAIL sof_nnin got %0d bad elements want 0", nnin_mismatches()); end
    release_frame();
    checks++; if (frameCount !== 8'(m_frames)) begin errors++; $display("FAIL sof_frames got %0d want %0d", frameCount, m_frames); end
  endtask

  task automatic test_random_valid();
    int cyc = 0;
    int bad = 0;
    n_acc = 0;
    acc_q.delete();
    while (!m_run && cyc < 20000) begin
      pixValid = $urandom_range(0, 1); pixSof = 1'b0; pixIn = PW'($urandom);
      tick();
      cyc++;
    end
    pixValid = 1'b0;
    checks++; if (!m_run) begin errors++; $display("FAIL rand_timeout got %0d accepts want %0d", n_acc, N); end
    checks++; if (n_acc != N) begin errors++; $display("FAIL rand_accepts got %0d want %0d", n_acc, N); end
    for (int i = 0; i < N && i < acc_q.size(); i++)
      if (int'(NNin[i*DW +: DW]) != acc_q[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_order got %0d bad elements want 0", bad); end
    checks++; if (NNvalid !== 1'b1) begin errors++; $display("FAIL rand_nnvalid got %0b want 1", NNvalid); end
    release_frame();
  endtask

  task automatic test_abort();
    int keep;
    int fc;
    load_random(500);
    keep = m_nnin[500];
    pixValid = 1'b1; abort = 1'b1; pixIn = ~PW'(keep);
    tick();
    pixValid = 1'b0; abort = 1'b0;
    checks++; if (int'(NNin[500*DW +: DW]) != keep) begin errors++; $display("FAIL abort_written got %h want %h", NNin[500*DW +: DW], keep); end
    checks++; if (pixCount !== '0) begin errors++; $display("FAIL abort_count got %0d want 0", pixCount); end
    checks++; if (NNvalid !== 1'b0) begin errors++; $display("FAIL abort_nnvalid got %0b want 0", NNvalid); end
    checks++; if (nnin_mismatches() != 0) begin errors++; $display("FAIL abort_nnin got %0d bad elements want 0", nnin_mismatches()); end
    load_random(N);
    fc = m_frames;
    abort = 1'b1; NNoutValid = 1'b1;
    tick();
    abort = 1'b0; NNoutValid = 1'b0;
    checks++; if (frameCount !== 8'(fc)) begin errors++; $display("FAIL abort_run_frames got %0d want %0d", frameCount, fc); end
    checks++; if (NNvalid !== 1'b0) begin errors++; $display("FAIL abort_run_nnvalid got %0b want 0", NNvalid); end
    checks++; if (pixCount !== '0) begin errors++; $display("FAIL abort_run_count got %0d want 0", pixCount); end
    checks++; if (pixReady !== 1'b1) begin errors++; $display("FAIL abort_run_ready got %0b want 1", pixReady); end
  endtask

  task automatic test_async_reset();
    load_random(N);
    checks++; if (NNvalid !== 1'b1) begin errors++; $display("FAIL ares_pre_nnvalid got %0b want 1", NNvalid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (NNvalid !== 1'b0) begin errors++; $display("FAIL ares_nnvalid got %0b want 0", NNvalid); end
    checks++; if (pixCount !== '0) begin errors++; $display("FAIL ares_count got %0d want 0", pixCount); end
    checks++; if (NNin !== '0) begin errors++; $display("FAIL ares_nnin nonzero want all 0"); end
    checks++; if (frameCount !== 8'd0) begin errors++; $display("FAIL ares_frames got %0d want 0", frameCount); end
    checks++; if (sofError !== 1'b0) begin errors++; $display("FAIL ares_soferr got %0b want 0", sofError); end
    model_reset();
    #3;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int exp_f = 0;
    int bad = 0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < NS; k++) begin
        s_pixValid = 1'b1; s_pixIn = PW'($urandom);
        @(posedge clk); #1;
      end
      s_pixValid = 1'b0;
      if (s_NNvalid !== 1'b1) bad++;
      s_NNoutValid = 1'b1;
      @(posedge clk); #1;
      s_NNoutValid = 1'b0;
      exp_f = (exp_f + 1) % 256;
      if (s_frameCount !== 8'(exp_f)) bad++;
      if (f == 254) begin
        checks++; if (s_frameCount !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d want 255", s_frameCount); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_seq got %0d bad frames want 0", bad); end
    checks++; if (s_frameCount !== 8'd0) begin errors++; $display("FAIL wrap_0 got %0d want 0", s_frameCount); end
  endtask

  initial begin
    reset_n = 1'b0;
    pixIn = '0; pixValid = 1'b0; pixSof = 1'b0; abort = 1'b0; NNoutValid = 1'b0;
    s_pixIn = '0; s_pixValid = 1'b0; s_NNoutValid = 1'b0;
    model_reset();
    #12;
    reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_full_frame();
    test_run_hold();
    test_sof();
    test_random_valid();
    test_abort();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
